// File: rtl/ddr5_mon_pkg.sv
// Shared types and constants for the DDR5 DIMM power monitor.
// The state enum and the fault-code constants are also used when decoding
// the fault register on the BMC side, so keep the encodings stable.
package ddr5_mon_pkg;

    // Supervisor states, in the order a normal power-up walks through them.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT_OK = 2'b01,
        ST_ALL_OK  = 2'b10,
        ST_FAULT   = 2'b11
    } mon_state_t;

    // Sticky fault codes reported on oFAULT_CODE.
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_MEMFLT  = 2'b10;
    localparam logic [1:0] FAULT_PGLOST  = 2'b11;

endpackage

// File: rtl/ddr5_flt_debounce.sv
// One-bit input filter. The filtered output takes the raw value only after
// DEBOUNCE_CYCLES consecutive samples disagree with it; any agreeing sample
// restarts the count. Output and counter both reset to 0.
module ddr5_flt_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count consecutive disagreeing samples and flip once the run is long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (raw == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= raw;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ddr5_dimm_pwr_monitor.sv
// Per-memory-controller power supervisor. Filters each MC's DRAM power-OK
// and memory-fault inputs, checks that all populated MCs come up within
// TIMEOUT_CYCLES of PS power-OK, and reports an aggregated power-good plus
// a sticky fault code and the MCs implicated.
// Build option: define DDR5_DIMM_FLT_DEBOUNCE_EN to instantiate the input
// debounce filters; without it the raw inputs feed the supervisor directly.
module ddr5_dimm_pwr_monitor
    import ddr5_mon_pkg::*;
#(
    parameter int MC_SIZE         = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 2000
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iPWRGD_PS_PWROK,
    input  logic [MC_SIZE-1:0] iMC_EN,
    input  logic [MC_SIZE-1:0] iPWRGD_DRAMPWRGD_OK,
    input  logic [MC_SIZE-1:0] iDIMM_MEM_FLT,
    input  logic               iFAULT_CLR,
    output logic               oMEM_PWRGD_ALL,
    output logic               oMEM_FAULT,
    output logic [1:0]         oFAULT_CODE,
    output logic [MC_SIZE-1:0] oFAULT_MC
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    mon_state_t         state;
    logic [TW-1:0]      timer;
    logic [MC_SIZE-1:0] ok_f;
    logic [MC_SIZE-1:0] flt_f;
    logic [MC_SIZE-1:0] ok_e;
    logic [MC_SIZE-1:0] flt_e;
    logic               all_ok;
    logic               any_flt;
    logic               pwrgd_q;
    logic               fault_q;
    logic [1:0]         code_q;
    logic [MC_SIZE-1:0] mc_q;

`ifdef DDR5_DIMM_FLT_DEBOUNCE_EN
    for (genvar g = 0; g < MC_SIZE; g++) begin : g_filt
        ddr5_flt_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ok_filt (
            .clk  (iClk),
            .rst  (iRst),
            .raw  (iPWRGD_DRAMPWRGD_OK[g]),
            .filt (ok_f[g])
        );
        ddr5_flt_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_flt_filt (
            .clk  (iClk),
            .rst  (iRst),
            .raw  (iDIMM_MEM_FLT[g]),
            .filt (flt_f[g])
        );
    end
`else
    // Without filtering the debounce length has no meaning.
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign ok_f  = iPWRGD_DRAMPWRGD_OK;
    assign flt_f = iDIMM_MEM_FLT;
`endif

    // Unpopulated MCs count as powered and can never fault.
    always_comb begin
        ok_e    = ~iMC_EN | ok_f;
        flt_e   = iMC_EN & flt_f;
        all_ok  = &ok_e;
        any_flt = |flt_e;
    end

    // Supervisor FSM; outputs are registered alongside the state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= ST_IDLE;
            timer   <= '0;
            pwrgd_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FAULT_NONE;
            mc_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iPWRGD_PS_PWROK) begin
                        state <= ST_WAIT_OK;
                        timer <= '0;
                    end
                end
                ST_WAIT_OK: begin
                    if (timer != TIMER_MAX) begin
                        timer <= timer + 1'b1;
                    end
                    // PS dropping is a normal power-down and wins over everything.
                    if (!iPWRGD_PS_PWROK) begin
                        state <= ST_IDLE;
                    end else if (all_ok) begin
                        state   <= ST_ALL_OK;
                        pwrgd_q <= 1'b1;
                    end else if (any_flt) begin
                        state   <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= FAULT_MEMFLT;
                        mc_q    <= flt_e;
                    end else if (timer == TIMER_LAST) begin
                        state   <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= FAULT_TIMEOUT;
                        mc_q    <= iMC_EN & ~ok_f;
                    end
                end
                ST_ALL_OK: begin
                    if (!iPWRGD_PS_PWROK) begin
                        state   <= ST_IDLE;
                        pwrgd_q <= 1'b0;
                    end else if (any_flt) begin
                        state   <= ST_FAULT;
                        pwrgd_q <= 1'b0;
                        fault_q <= 1'b1;
                        code_q  <= FAULT_MEMFLT;
                        mc_q    <= flt_e;
                    end else if (!all_ok) begin
                        state   <= ST_FAULT;
                        pwrgd_q <= 1'b0;
                        fault_q <= 1'b1;
                        code_q  <= FAULT_PGLOST;
                        mc_q    <= ~ok_e;
                    end
                end
                ST_FAULT: begin
                    // Clearing is only honoured once the supply is down.
                    if (iFAULT_CLR && !iPWRGD_PS_PWROK) begin
                        state   <= ST_IDLE;
                        fault_q <= 1'b0;
                        code_q  <= FAULT_NONE;
                        mc_q    <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oMEM_PWRGD_ALL = pwrgd_q;
    assign oMEM_FAULT     = fault_q;
    assign oFAULT_CODE    = code_q;
    assign oFAULT_MC      = mc_q;

endmodule

// File: tb/tb_ddr5_dimm_pwr_monitor.sv
// Bench for ddr5_dimm_pwr_monitor: a directed vector table and hand-written
// sequences for the multi-cycle corners, then randomized stimulus. A
// behavioural model runs alongside and is compared every cycle.
module tb_ddr5_dimm_pwr_monitor;

    localparam int MC = 4;
    localparam int D  = 4;
    localparam int T  = 50;
`ifdef DDR5_DIMM_FLT_DEBOUNCE_EN
    localparam int DEB_EN = 1;
`else
    localparam int DEB_EN = 0;
`endif
    // Edges from a raw input change to the supervisor reacting.
    localparam int LAT   = DEB_EN ? D + 1 : 1;
    localparam int PULSE = DEB_EN ? D : 1;

    logic          iClk;
    logic          iRst;
    logic          iPWRGD_PS_PWROK;
    logic [MC-1:0] iMC_EN;
    logic [MC-1:0] iPWRGD_DRAMPWRGD_OK;
    logic [MC-1:0] iDIMM_MEM_FLT;
    logic          iFAULT_CLR;
    logic          oMEM_PWRGD_ALL;
    logic          oMEM_FAULT;
    logic [1:0]    oFAULT_CODE;
    logic [MC-1:0] oFAULT_MC;

    int n_checks = 0;
    int n_pass   = 0;

    ddr5_dimm_pwr_monitor #(
        .MC_SIZE        (MC),
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .iClk               (iClk),
        .iRst               (iRst),
        .iPWRGD_PS_PWROK    (iPWRGD_PS_PWROK),
        .iMC_EN             (iMC_EN),
        .iPWRGD_DRAMPWRGD_OK(iPWRGD_DRAMPWRGD_OK),
        .iDIMM_MEM_FLT      (iDIMM_MEM_FLT),
        .iFAULT_CLR         (iFAULT_CLR),
        .oMEM_PWRGD_ALL     (oMEM_PWRGD_ALL),
        .oMEM_FAULT         (oMEM_FAULT),
        .oFAULT_CODE        (oFAULT_CODE),
        .oFAULT_MC          (oFAULT_MC)
    );

    // ---------------- clock ----------------
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_WAIT, M_OK, M_FAULT} m_state_t;
    m_state_t      m_state;
    int            m_cyc;
    int            m_entry;
    logic          m_pwrgd;
    logic          m_fault;
    logic [1:0]    m_code;
    logic [MC-1:0] m_mc;
    logic [MC-1:0] m_okf;
    logic [MC-1:0] m_fltf;
    int            run_ok  [MC];
    int            run_flt [MC];
    logic [MC-1:0] okv;
    logic [MC-1:0] fltv;
    logic [MC-1:0] oke;
    logic [MC-1:0] flte;

    // What the supervisor sees this edge: filtered history or raw pins.
    always_comb begin
        okv  = DEB_EN ? m_okf  : iPWRGD_DRAMPWRGD_OK;
        fltv = DEB_EN ? m_fltf : iDIMM_MEM_FLT;
        oke  = ~iMC_EN | okv;
        flte = iMC_EN & fltv;
    end

    // Model of the supervisor rules; elapsed time is counted as edges since entry.
    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            m_state <= M_IDLE;
            m_cyc   <= 0;
            m_entry <= 0;
            m_pwrgd <= 1'b0;
            m_fault <= 1'b0;
            m_code  <= 2'b00;
            m_mc    <= '0;
            m_okf   <= '0;
            m_fltf  <= '0;
            for (int i = 0; i < MC; i++) begin
                run_ok[i]  <= 0;
                run_flt[i] <= 0;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            case (m_state)
                M_IDLE: if (iPWRGD_PS_PWROK) begin
                    m_state <= M_WAIT;
                    m_entry <= m_cyc + 1;
                end
                M_WAIT: begin
                    if (!iPWRGD_PS_PWROK) m_state <= M_IDLE;
                    else if (oke == {MC{1'b1}}) begin
                        m_state <= M_OK; m_pwrgd <= 1'b1;
                    end else if (flte != 0) begin
                        m_state <= M_FAULT; m_fault <= 1'b1; m_code <= 2'd2; m_mc <= flte;
                    end else if (m_cyc + 1 - m_entry == T) begin
                        m_state <= M_FAULT; m_fault <= 1'b1; m_code <= 2'd1; m_mc <= iMC_EN & ~okv;
                    end
                end
                M_OK: begin
                    if (!iPWRGD_PS_PWROK) begin
                        m_state <= M_IDLE; m_pwrgd <= 1'b0;
                    end else if (flte != 0) begin
                        m_state <= M_FAULT; m_pwrgd <= 1'b0; m_fault <= 1'b1; m_code <= 2'd2; m_mc <= flte;
                    end else if (oke != {MC{1'b1}}) begin
                        m_state <= M_FAULT; m_pwrgd <= 1'b0; m_fault <= 1'b1; m_code <= 2'd3; m_mc <= ~oke;
                    end
                end
                default: if (iFAULT_CLR && !iPWRGD_PS_PWROK) begin
                    m_state <= M_IDLE; m_fault <= 1'b0; m_code <= 2'd0; m_mc <= '0;
                end
            endcase
            for (int i = 0; i < MC; i++) begin
                if (iPWRGD_DRAMPWRGD_OK[i] == m_okf[i]) run_ok[i] <= 0;
                else if (run_ok[i] + 1 == D) begin
                    m_okf[i] <= iPWRGD_DRAMPWRGD_OK[i]; run_ok[i] <= 0;
                end else run_ok[i] <= run_ok[i] + 1;
                if (iDIMM_MEM_FLT[i] == m_fltf[i]) run_flt[i] <= 0;
                else if (run_flt[i] + 1 == D) begin
                    m_fltf[i] <= iDIMM_MEM_FLT[i]; run_flt[i] <= 0;
                end else run_flt[i] <= run_flt[i] + 1;
            end
        end
    end

    // Compare the DUT against the model every cycle, away from the active edge.
    always @(negedge iClk) begin
        check("mdl_pwrgd", 32'(oMEM_PWRGD_ALL), 32'(m_pwrgd));
        check("mdl_fault", 32'(oMEM_FAULT), 32'(m_fault));
        check("mdl_code",  32'(oFAULT_CODE), 32'(m_code));
        check("mdl_mc",    32'(oFAULT_MC), 32'(m_mc));
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          ps;
        logic [MC-1:0] en;
        logic [MC-1:0] ok;
        logic [MC-1:0] flt;
        logic          clr;
        int            cyc;
        logic          e_pwrgd;
        logic          e_fault;
        logic [1:0]    e_code;
        logic [MC-1:0] e_mc;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic ps, logic [MC-1:0] en, logic [MC-1:0] ok, logic [MC-1:0] flt,
                                logic clr, int cyc, logic ep, logic ef, logic [1:0] ec, logic [MC-1:0] em);
        vec_t v;
        v.ps = ps; v.en = en; v.ok = ok; v.flt = flt; v.clr = clr; v.cyc = cyc;
        v.e_pwrgd = ep; v.e_fault = ef; v.e_code = ec; v.e_mc = em;
        return v;
    endfunction

    task automatic drive(input logic ps, input logic [MC-1:0] en, input logic [MC-1:0] ok,
                         input logic [MC-1:0] flt, input logic clr);
        iPWRGD_PS_PWROK     = ps;
        iMC_EN              = en;
        iPWRGD_DRAMPWRGD_OK = ok;
        iDIMM_MEM_FLT       = flt;
        iFAULT_CLR          = clr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic expect_out(input string tag, input logic p, input logic f,
                              input logic [1:0] c, input logic [MC-1:0] m);
        check({tag, "_pwrgd"}, 32'(oMEM_PWRGD_ALL), 32'(p));
        check({tag, "_fault"}, 32'(oMEM_FAULT), 32'(f));
        check({tag, "_code"},  32'(oFAULT_CODE), 32'(c));
        check({tag, "_mc"},    32'(oFAULT_MC), 32'(m));
    endtask

    task automatic run_steps(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            drive(vecs[k].ps, vecs[k].en, vecs[k].ok, vecs[k].flt, vecs[k].clr);
            tick(vecs[k].cyc);
            expect_out($sformatf("v%0d", k), vecs[k].e_pwrgd, vecs[k].e_fault, vecs[k].e_code, vecs[k].e_mc);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int hold;
        iRst = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0);
        tick(2);
        iRst = 1'b0;

        // Power-up, boundary of debounce latency, then fault/clear/timeout/priority cases.
        vecs[0]  = mk(0, 4'hF, 4'h0, 4'h0, 0, 2,       0, 0, 2'd0, 4'h0);
        vecs[1]  = mk(1, 4'hF, 4'h0, 4'h0, 0, 10,      0, 0, 2'd0, 4'h0);
        vecs[2]  = mk(1, 4'hF, 4'hF, 4'h0, 0, LAT - 1, 0, 0, 2'd0, 4'h0);
        vecs[3]  = mk(1, 4'hF, 4'hF, 4'h0, 0, 1,       1, 0, 2'd0, 4'h0);
        vecs[4]  = mk(1, 4'hF, 4'hF, 4'h0, 1, 3,       0, 1, 2'd2, 4'h4);
        vecs[5]  = mk(0, 4'hF, 4'hF, 4'h0, 1, 1,       0, 0, 2'd0, 4'h0);
        vecs[6]  = mk(0, 4'h7, 4'hD, 4'h0, 0, LAT + 2, 0, 0, 2'd0, 4'h0);
        vecs[7]  = mk(1, 4'h7, 4'hD, 4'h0, 0, T,       0, 0, 2'd0, 4'h0);
        vecs[8]  = mk(1, 4'h7, 4'hD, 4'h0, 0, 1,       0, 1, 2'd1, 4'h2);
        vecs[9]  = mk(1, 4'h7, 4'hD, 4'h0, 1, 2,       0, 1, 2'd1, 4'h2);
        vecs[10] = mk(0, 4'h7, 4'hD, 4'h0, 1, 1,       0, 0, 2'd0, 4'h0);
        vecs[11] = mk(1, 4'hF, 4'hF, 4'h0, 0, LAT + 2, 1, 0, 2'd0, 4'h0);
        vecs[12] = mk(1, 4'hF, 4'hE, 4'h8, 0, LAT,     0, 1, 2'd2, 4'h8);
        vecs[13] = mk(0, 4'hF, 4'hF, 4'h0, 1, 1,       0, 0, 2'd0, 4'h0);
        vecs[14] = mk(0, 4'hF, 4'hF, 4'h0, 0, LAT + 1, 0, 0, 2'd0, 4'h0);
        vecs[15] = mk(1, 4'hF, 4'hF, 4'h0, 0, 2,       1, 0, 2'd0, 4'h0);
        vecs[16] = mk(0, 4'hF, 4'h0, 4'h0, 0, 1,       0, 0, 2'd0, 4'h0);
        vecs[17] = mk(0, 4'hF, 4'h0, 4'h0, 0, LAT + 2, 0, 0, 2'd0, 4'h0);
        vecs[18] = mk(1, 4'hF, 4'hF, 4'h0, 0, LAT + 2, 1, 0, 2'd0, 4'h0);
        vecs[19] = mk(1, 4'hF, 4'hE, 4'h0, 0, LAT,     0, 1, 2'd3, 4'h1);
        vecs[20] = mk(0, 4'h0, 4'h0, 4'h0, 0, 2,       0, 0, 2'd0, 4'h0);
        vecs[21] = mk(1, 4'h0, 4'h0, 4'h0, 0, 2,       1, 0, 2'd0, 4'h0);
        vecs[22] = mk(1, 4'h0, 4'h0, 4'hF, 0, LAT + 2, 1, 0, 2'd0, 4'h0);
        vecs[23] = mk(0, 4'h0, 4'h0, 4'h0, 0, 1,       0, 0, 2'd0, 4'h0);

        run_steps(0, 3);

`ifdef DDR5_DIMM_FLT_DEBOUNCE_EN
        // A glitch one sample short of the debounce length must be ignored.
        drive(1, 4'hF, 4'hF, 4'h4, 0);
        tick(D - 1);
        drive(1, 4'hF, 4'hF, 4'h0, 0);
        tick(D + 2);
        expect_out("glitch", 1'b1, 1'b0, 2'd0, 4'h0);
`endif

        // A pulse just long enough to pass the filter latches a mem fault.
        drive(1, 4'hF, 4'hF, 4'h4, 0);
        tick(PULSE);
        drive(1, 4'hF, 4'hF, 4'h0, 0);
        tick(LAT - PULSE);
        expect_out("pulse", 1'b0, 1'b1, 2'd2, 4'h4);

        run_steps(4, 19);

        // Asynchronous reset while a fault is latched clears everything at once.
        #2 iRst = 1'b1;
        #1 expect_out("arst", 1'b0, 1'b0, 2'd0, 4'h0);
        @(negedge iClk);
        iRst = 1'b0;

        run_steps(20, 23);

        // Randomized stimulus, held for a while so filters and timeouts engage.
        for (int it = 0; it < 1500; it++) begin
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 8);
            drive(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 2) == 0) ? MC'($urandom_range(0, 15)) : 4'hF,
                  ($urandom_range(0, 3) == 0) ? MC'($urandom_range(0, 15)) : 4'hF,
                  ($urandom_range(0, 9) == 0) ? MC'($urandom_range(0, 15)) : 4'h0,
                  ($urandom_range(0, 3) == 0));
            tick(hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
